// File: rtl/mux_scan_if.sv
`default_nettype none
// mux_scan_if: data, control and result bundle for the mux_scan block. Rev 1.0
interface mux_scan_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 4,
  parameter int SEL_W    = 3,
  parameter int DWELL_W  = 8
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [DWELL_W-1:0]        dwell;
  logic [CHANNELS-1:0]       ch_en;

  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      wrap;

  modport master (
    output in_data, mode, sel, dwell, ch_en,
    input  out, out_ch, out_valid, wrap
  );

  modport slave (
    input  in_data, mode, sel, dwell, ch_en,
    output out, out_ch, out_valid, wrap
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan.sv
`default_nettype none
// mux_scan: registered N-channel mux with manual select and a dwell-timed
// scan over an enable mask, reporting channel, valid and wrap. Rev 1.0
module mux_scan #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 4,
  parameter int SEL_W    = 3,
  parameter int DWELL_W  = 8
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam int              IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SEL_W:0]  CH_LIMIT = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0] w_ch_data [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign w_ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
  end

  state_t             r_state, w_state;
  logic [SEL_W-1:0]   r_cur, w_cur;
  logic [DWELL_W-1:0] r_cnt, w_cnt;
  logic               r_wrapped, w_wrapped;
  logic [WIDTH-1:0]   r_out, w_out;
  logic [SEL_W-1:0]   r_out_ch, w_out_ch;
  logic               r_valid, w_valid;
  logic               r_wrap, w_wrap;

  logic [SEL_W-1:0]   w_lowest;
  logic [SEL_W-1:0]   w_next;
  logic [DWELL_W-1:0] w_dwell_last;
  logic               w_sel_ok;
  logic               w_cur_en;
  logic               w_any_en;

  assign w_sel_ok     = ({1'b0, bus.sel} < CH_LIMIT);
  assign w_dwell_last = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  assign w_cur_en     = bus.ch_en[IDX_W'(r_cur)];
  assign w_any_en     = (bus.ch_en != '0);

  always_comb begin
    w_lowest = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (bus.ch_en[IDX_W'(i)]) w_lowest = SEL_W'(i);
    end
  end

  // Rotate-and-find-first: walk offsets from the far end so the nearest
  // enabled channel above cur is the last one written.
  always_comb begin
    int idx;
    idx    = 0;
    w_next = r_cur;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = int'(r_cur) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (bus.ch_en[IDX_W'(idx)]) w_next = SEL_W'(idx);
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cur     = r_cur;
    w_cnt     = r_cnt;
    w_wrapped = 1'b0;
    w_out     = r_out;
    w_out_ch  = r_out_ch;
    w_valid   = 1'b0;
    w_wrap    = 1'b0;

    if (!bus.mode) begin
      w_state  = ST_MANUAL;
      w_cur    = '0;
      w_cnt    = '0;
      w_out    = w_sel_ok ? w_ch_data[IDX_W'(bus.sel)] : '0;
      w_out_ch = bus.sel;
      w_valid  = w_sel_ok;
    end else if (!w_any_en) begin
      w_state = ST_HALT;
      w_cnt   = '0;
    end else if (r_state != ST_SCAN) begin
      w_state = ST_SCAN;
      w_cur   = w_lowest;
      w_cnt   = '0;
    end else begin
      // The wrap flag is delayed one cycle so it marks the first sample
      // of the channel reached by the wrapping advance.
      w_out    = w_ch_data[IDX_W'(r_cur)];
      w_out_ch = r_cur;
      w_valid  = 1'b1;
      w_wrap   = r_wrapped;
      if (!w_cur_en || (r_cnt >= w_dwell_last)) begin
        w_cur     = w_next;
        w_cnt     = '0;
        w_wrapped = (w_next <= r_cur);
      end else begin
        w_cnt = r_cnt + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_MANUAL;
      r_cur     <= '0;
      r_cnt     <= '0;
      r_wrapped <= 1'b0;
      r_out     <= '0;
      r_out_ch  <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cur     <= w_cur;
      r_cnt     <= w_cnt;
      r_wrapped <= w_wrapped;
      r_out     <= w_out;
      r_out_ch  <= w_out_ch;
      r_valid   <= w_valid;
      r_wrap    <= w_wrap;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_valid;
  assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// tb_mux_scan: table vectors, directed scan sequences and a randomized
// reference-model comparison for mux_scan at 8 and 6 channels.
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic [7:0] ch_en;
  logic [31:0] in_data;

  int vectors     = 0;
  int miscompares = 0;

  mux_scan_if #(.CHANNELS(8), .WIDTH(4), .SEL_W(3), .DWELL_W(8)) b8();
  mux_scan_if #(.CHANNELS(6), .WIDTH(4), .SEL_W(3), .DWELL_W(8)) b6();

  assign b8.in_data = in_data;
  assign b8.mode    = mode;
  assign b8.sel     = sel;
  assign b8.dwell   = dwell;
  assign b8.ch_en   = ch_en;
  assign b6.in_data = in_data[23:0];
  assign b6.mode    = mode;
  assign b6.sel     = sel;
  assign b6.dwell   = dwell;
  assign b6.ch_en   = ch_en[5:0];

  mux_scan #(.CHANNELS(8), .WIDTH(4), .SEL_W(3), .DWELL_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave)
  );
  mux_scan #(.CHANNELS(6), .WIDTH(4), .SEL_W(3), .DWELL_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(b6.slave)
  );

  // Fixed channel contents for the directed part; channel 5 carries 4'hA.
  logic [3:0] chval [8] = '{4'hC, 4'h1, 4'h2, 4'h3, 4'h9, 4'hA, 4'hE, 4'hF};

  typedef struct {
    bit         rst_n;
    logic [2:0] sel;
    logic [3:0] e8_out;
    logic [2:0] e_ch;
    bit         e8_val;
    logic [3:0] e6_out;
    bit         e6_val;
  } vec_t;
  vec_t tbl [9];

  typedef struct {
    bit         scanning;
    int         cur;
    int         emitted;
    bit         pend;
    logic [3:0] out;
    int         ch;
    bit         valid;
    bit         wrap;
  } model_t;
  model_t m8, m6;

  int sweep [12] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 0, 0, 0};
  int fast  [6]  = '{0, 2, 5, 0, 2, 5};
  int medit [5]  = '{2, 5, 5, 5, 0};

  function automatic logic [3:0] chan(input int k);
    return in_data[k*4 +: 4];
  endfunction

  // Behavioural reference: counts samples emitted on the current channel and
  // picks the next channel from the list of enabled indices.
  function automatic model_t model_step(input model_t m, input int nch);
    model_t n;
    int     en_list[$];
    int     nxt;
    bit     found;
    n      = m;
    n.wrap = 1'b0;
    for (int k = 0; k < nch; k++) if (ch_en[k]) en_list.push_back(k);
    if (!rst_n) begin
      n.scanning = 0; n.cur = 0; n.emitted = 0; n.pend = 0;
      n.out = 4'h0; n.ch = 0; n.valid = 0;
    end else if (!mode) begin
      n.scanning = 0;
      n.ch       = int'(sel);
      n.valid    = (int'(sel) < nch);
      n.out      = n.valid ? chan(int'(sel)) : 4'h0;
    end else if (en_list.size() == 0) begin
      n.scanning = 0;
      n.valid    = 0;
    end else if (!m.scanning) begin
      n.scanning = 1; n.cur = en_list[0]; n.emitted = 0; n.pend = 0;
      n.valid    = 0;
    end else begin
      n.out = chan(m.cur); n.ch = m.cur; n.valid = 1;
      n.wrap = m.pend; n.pend = 0;
      n.emitted = m.emitted + 1;
      if (!ch_en[m.cur] || n.emitted >= ((dwell == 0) ? 1 : int'(dwell))) begin
        nxt = en_list[0];
        found = 0;
        for (int j = 0; j < en_list.size(); j++) begin
          if (!found && en_list[j] > m.cur) begin
            nxt = en_list[j];
            found = 1;
          end
        end
        n.pend = (nxt <= m.cur);
        n.cur = nxt;
        n.emitted = 0;
      end
    end
    return n;
  endfunction

  task automatic tick();
    m8 = model_step(m8, 8);
    m6 = model_step(m6, 6);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmp(input string name,
                     input logic [3:0] ao, input logic [2:0] ach, input logic av, input logic aw,
                     input logic [3:0] eo, input logic [2:0] ech, input logic ev, input logic ew);
    vectors++;
    if (ao !== eo || ach !== ech || av !== ev || aw !== ew) begin
      miscompares++;
      $display("FAIL %s @%0t: got out=%h out_ch=%0d valid=%b wrap=%b, want out=%h out_ch=%0d valid=%b wrap=%b",
               name, $time, ao, ach, av, aw, eo, ech, ev, ew);
    end
  endtask

  task automatic chk8(input string name, input logic [3:0] eo, input logic [2:0] ech,
                      input logic ev, input logic ew);
    cmp(name, b8.out, b8.out_ch, b8.out_valid, b8.wrap, eo, ech, ev, ew);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) in_data[k*4 +: 4] = chval[k];
    rst_n = 1'b0; mode = 1'b0; sel = 3'd5; dwell = 8'd3; ch_en = 8'b0010_0101;
    m8 = '{scanning: 0, cur: 0, emitted: 0, pend: 0, out: 4'h0, ch: 0, valid: 0, wrap: 0};
    m6 = m8;

    // Reset and manual selection, including selects beyond 6 channels.
    tbl[0] = '{0, 3'd5, 4'h0, 3'd0, 0, 4'h0, 0};
    tbl[1] = '{0, 3'd5, 4'h0, 3'd0, 0, 4'h0, 0};
    tbl[2] = '{0, 3'd5, 4'h0, 3'd0, 0, 4'h0, 0};
    tbl[3] = '{1, 3'd5, 4'hA, 3'd5, 1, 4'hA, 1};
    tbl[4] = '{1, 3'd7, 4'hF, 3'd7, 1, 4'h0, 0};
    tbl[5] = '{1, 3'd2, 4'h2, 3'd2, 1, 4'h2, 1};
    tbl[6] = '{1, 3'd6, 4'hE, 3'd6, 1, 4'h0, 0};
    tbl[7] = '{1, 3'd0, 4'hC, 3'd0, 1, 4'hC, 1};
    tbl[8] = '{1, 3'd4, 4'h9, 3'd4, 1, 4'h9, 1};
    for (int i = 0; i < 9; i++) begin
      rst_n = tbl[i].rst_n;
      sel   = tbl[i].sel;
      tick();
      cmp("table8", b8.out, b8.out_ch, b8.out_valid, b8.wrap,
          tbl[i].e8_out, tbl[i].e_ch, tbl[i].e8_val, 1'b0);
      cmp("table6", b6.out, b6.out_ch, b6.out_valid, b6.wrap,
          tbl[i].e6_out, tbl[i].e_ch, tbl[i].e6_val, 1'b0);
    end

    // Scan sweep over channels 0,2,5 with dwell 3.
    mode = 1'b1;
    tick();
    chk8("scan_enter", 4'h9, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk8("sweep", chval[sweep[i]], 3'(sweep[i]), 1'b1, (i == 9));
    end

    // Dwell 0 and dwell 1 both advance every cycle.
    for (int d = 0; d < 2; d++) begin
      mode = 1'b0; sel = 3'd1; dwell = 8'(d);
      tick();
      chk8("dwell_manual", 4'h1, 3'd1, 1'b1, 1'b0);
      mode = 1'b1;
      tick();
      chk8("dwell_enter", 4'h1, 3'd1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        tick();
        chk8("dwell_fast", chval[fast[i]], 3'(fast[i]), 1'b1, (i == 3));
      end
    end

    // Mask edit while dwelling on channel 2.
    dwell = 8'd3; mode = 1'b0; sel = 3'd1;
    tick();
    mode = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk8("medit_pre", chval[sweep[i]], 3'(sweep[i]), 1'b1, 1'b0);
    end
    ch_en = 8'b0010_0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk8("medit_skip", chval[medit[i]], 3'(medit[i]), 1'b1, (i == 4));
    end
    ch_en = 8'h00;
    tick();
    chk8("halt_hold", 4'hC, 3'd0, 1'b0, 1'b0);
    tick();
    chk8("halt_stay", 4'hC, 3'd0, 1'b0, 1'b0);
    ch_en = 8'h01;
    tick();
    chk8("halt_leave", 4'hC, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk8("single_ch", 4'hC, 3'd0, 1'b1, (i == 3 || i == 6));
    end

    // Mode toggling and a reset in the middle of a scan.
    ch_en = 8'b0010_0101; mode = 1'b0; sel = 3'd3;
    tick();
    chk8("to_manual", 4'h3, 3'd3, 1'b1, 1'b0);
    mode = 1'b1;
    tick();
    chk8("reenter", 4'h3, 3'd3, 1'b0, 1'b0);
    tick();
    chk8("reenter_low", 4'hC, 3'd0, 1'b1, 1'b0);
    tick();
    chk8("reenter_dwell", 4'hC, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk8("mid_reset", 4'h0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk8("post_reset_enter", 4'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk8("post_reset_scan", 4'hC, 3'd0, 1'b1, 1'b0);

    // Randomized traffic against the reference model on both widths.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0)
        ch_en = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 4));
      sel     = 3'($urandom_range(0, 7));
      in_data = $urandom;
      tick();
      cmp("rand8", b8.out, b8.out_ch, b8.out_valid, b8.wrap,
          m8.out, 3'(m8.ch), m8.valid, m8.wrap);
      cmp("rand6", b6.out, b6.out_ch, b6.out_valid, b6.wrap,
          m6.out, 3'(m6.ch), m6.valid, m6.wrap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
